remote_cmd_wrapper: RTL and testbench
=====================================

Name: remote_cmd_wrapper

Overview:
- DUT-side counterpart of the host command transmitter.
- Sits between the DUT's 8-bit UART transceiver and the command processor.
- Assembles two received bytes (high byte first) into a 16-bit command with a ready/clear handshake, plus inter-byte timeout resync.
- Forwards 8-bit responses from the command processor to the UART transmitter through a one-entry holding buffer.

Parameters:
TO_CYCLES, 100000, inter-byte timeout in clk cycles (≥2); counter width is clog2(TO_CYCLES).

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  asynchronous active-high reset
rx_rdy  input  1  UART byte-received flag (level; held until cleared)
rx_data  input  8  UART received byte
clr_rx_rdy  output  1  combinational clear to UART, same cycle a byte is taken
cmd  output  16  assembled command {high, low}
cmd_rdy  output  1  command valid (level)
clr_cmd_rdy  input  1  consumer acknowledge; clears cmd_rdy
frame_err  output  1  one-cycle pulse, half-command dropped by timeout
overrun  output  1  one-cycle pulse, new command overwrote an unconsumed one
resp  input  8  response byte
send_resp  input  1  one-cycle request to transmit resp
tx_data  output  8  byte to UART transmitter
trmt  output  1  one-cycle transmit start to UART
tx_done  input  1  UART transmitter finished a byte (pulse)
resp_drop  output  1  one-cycle pulse, response discarded (buffer full)

Behaviour:
- Reset (async, rst=1): state=HIGH; cmd=0; cmd_rdy=0; high-byte reg=0; timeout cnt=0; tx_busy=0; buf_vld=0; tx_data=0. trmt, frame_err, overrun, resp_drop, clr_rx_rdy all 0. Reset mid-frame discards any half-command and any buffered response.
- RX FSM, states HIGH, LOW:
  - HIGH: if rx_rdy, capture rx_data as high byte, assert clr_rx_rdy this cycle, clear cnt, go to LOW.
  - HIGH: capturing a high byte does not clear a pending cmd_rdy.
  - LOW: if rx_rdy, register cmd = {high, rx_data}, set cmd_rdy, assert clr_rx_rdy, go to HIGH.
  - LOW: if cmd_rdy was already 1 and clr_cmd_rdy is not asserted this cycle, pulse overrun with the update.
  - LOW, no rx_rdy: cnt increments. When cnt = TO_CYCLES-1 without rx_rdy, drop the high byte, pulse frame_err, go to HIGH, clear cnt.
  - LOW: rx_rdy on the same cycle as the timeout terminal count counts as on-time; the low byte is accepted.
- clr_rx_rdy is combinational, high only on capture cycles. UART clears rx_rdy on the next edge, so each byte is taken exactly once.
- cmd/cmd_rdy timing: visible the cycle after the low byte is taken (1-cycle latency from rx_rdy).
  - clr_cmd_rdy clears cmd_rdy next edge; cmd holds its value.
  - Set and clear on the same cycle: set wins.
- TX path:
  - send_resp with tx_busy=0: tx_data<=resp, trmt pulses next cycle, tx_busy<=1.
  - send_resp with tx_busy=1 and buf_vld=0: store resp in buffer, buf_vld<=1.
  - send_resp with tx_busy=1 and buf_vld=1: pulse resp_drop; buffer unchanged.
  - tx_done with buf_vld=1: load buffer into tx_data, pulse trmt next cycle, buf_vld<=0, tx_busy stays 1.
  - tx_done with buf_vld=0: tx_busy<=0.
  - tx_done and send_resp on the same cycle with buf_vld=0: resp launches directly (no buffering, no drop).
- trmt is never high on two consecutive cycles. tx_data is stable from trmt until the next tx_done.
- RX and TX paths are fully independent.

Test Plan:
- Byte 0xA5 then 0x3C on rx_rdy/rx_data -> one clr_rx_rdy per byte; cmd=0xA53C, cmd_rdy=1 one cycle after second byte. clr_cmd_rdy -> cmd_rdy=0, cmd stays 0xA53C.
- TO_CYCLES=16: send byte 0x12, wait 16 cycles, then send 0x34, 0x56 -> frame_err pulses once, 0x12 discarded, cmd=0x3456.
- Low byte arrives exactly at cnt=TO_CYCLES-1 -> command accepted, no frame_err.
- Two commands 0x1111, 0x2222 with no clr_cmd_rdy -> overrun pulse on second, cmd=0x2222. Repeat with clr_cmd_rdy on the completion cycle -> no overrun, cmd_rdy=1.
- send_resp 0xA5 (idle), then 0x5A, then 0xFF while busy -> 0xA5 transmitted, 0x5A buffered, 0xFF gives resp_drop. After tx_done, trmt with tx_data=0x5A; after second tx_done, tx_busy=0.
- Assert rst mid-frame (state LOW) and with buf_vld=1 -> all outputs 0 immediately. Next two bytes 0x00, 0x07 give cmd=0x0007, and no buffered trmt occurs.

Source files
------------

// File: rtl/remote_cmd_wrapper.sv
// DUT-side command receiver / response transmitter between a byte UART and the command processor.
// Two received bytes (high first) form a 16-bit command; responses go out through a one-entry buffer.
module remote_cmd_wrapper #(
  parameter int unsigned TO_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        frame_err,
  output logic        overrun,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic [7:0]  tx_data,
  output logic        trmt,
  input  logic        tx_done,
  output logic        resp_drop
);

  localparam int unsigned CW = $clog2(TO_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TO_CYCLES - 1);

  typedef enum logic {
    ST_HIGH,
    ST_LOW
  } rx_state_e;

  rx_state_e       state_q, state_d;
  logic [7:0]      hi_q, hi_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     cmd_q, cmd_d;
  logic            cmd_rdy_q, cmd_rdy_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;

  logic            tx_busy_q, tx_busy_d;
  logic            buf_vld_q, buf_vld_d;
  logic [7:0]      buf_q, buf_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            trmt_q, trmt_d;
  logic            resp_drop_q, resp_drop_d;

  // RX assembly: the low byte wins over the timeout on the terminal-count cycle.
  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    cmd_rdy_d   = cmd_rdy_q & ~clr_cmd_rdy;
    clr_rx_rdy  = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    case (state_q)
      ST_HIGH: begin
        if (rx_rdy) begin
          hi_d       = rx_data;
          clr_rx_rdy = 1'b1;
          cnt_d      = '0;
          state_d    = ST_LOW;
        end
      end
      ST_LOW: begin
        if (rx_rdy) begin
          cmd_d      = {hi_q, rx_data};
          cmd_rdy_d  = 1'b1;
          overrun_d  = cmd_rdy_q & ~clr_cmd_rdy;
          clr_rx_rdy = 1'b1;
          cnt_d      = '0;
          state_d    = ST_HIGH;
        end else if (cnt_q == CNT_LAST) begin
          hi_d        = '0;
          frame_err_d = 1'b1;
          cnt_d       = '0;
          state_d     = ST_HIGH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_HIGH;
    endcase
  end

  // TX: a tx_done frees the transmitter in the same cycle, so a coincident request launches directly.
  always_comb begin
    tx_busy_d   = tx_busy_q;
    buf_vld_d   = buf_vld_q;
    buf_d       = buf_q;
    tx_data_d   = tx_data_q;
    trmt_d      = 1'b0;
    resp_drop_d = 1'b0;
    if (tx_done) begin
      if (buf_vld_q) begin
        tx_data_d = buf_q;
        trmt_d    = 1'b1;
        buf_vld_d = 1'b0;
        if (send_resp) begin
          buf_d     = resp;
          buf_vld_d = 1'b1;
        end
      end else if (send_resp) begin
        tx_data_d = resp;
        trmt_d    = 1'b1;
        tx_busy_d = 1'b1;
      end else begin
        tx_busy_d = 1'b0;
      end
    end else if (send_resp) begin
      if (!tx_busy_q) begin
        tx_data_d = resp;
        trmt_d    = 1'b1;
        tx_busy_d = 1'b1;
      end else if (!buf_vld_q) begin
        buf_d     = resp;
        buf_vld_d = 1'b1;
      end else begin
        resp_drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_HIGH;
      hi_q        <= '0;
      cnt_q       <= '0;
      cmd_q       <= '0;
      cmd_rdy_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      tx_busy_q   <= 1'b0;
      buf_vld_q   <= 1'b0;
      buf_q       <= '0;
      tx_data_q   <= '0;
      trmt_q      <= 1'b0;
      resp_drop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      cmd_rdy_q   <= cmd_rdy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      tx_busy_q   <= tx_busy_d;
      buf_vld_q   <= buf_vld_d;
      buf_q       <= buf_d;
      tx_data_q   <= tx_data_d;
      trmt_q      <= trmt_d;
      resp_drop_q <= resp_drop_d;
    end
  end

  assign cmd       = cmd_q;
  assign cmd_rdy   = cmd_rdy_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign tx_data   = tx_data_q;
  assign trmt      = trmt_q;
  assign resp_drop = resp_drop_q;

endmodule

// File: tb/tb_remote_cmd_wrapper.sv
// Directed bench for remote_cmd_wrapper with a short inter-byte timeout.
module tb_remote_cmd_wrapper;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        frame_err;
  logic        overrun;
  logic [7:0]  resp = '0;
  logic        send_resp = 1'b0;
  logic [7:0]  tx_data;
  logic        trmt;
  logic        tx_done = 1'b0;
  logic        resp_drop;

  int checks = 0;
  int errors = 0;

  remote_cmd_wrapper #(.TO_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data), .clr_rx_rdy(clr_rx_rdy),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .frame_err(frame_err),
    .overrun(overrun), .resp(resp), .send_resp(send_resp), .tx_data(tx_data),
    .trmt(trmt), .tx_done(tx_done), .resp_drop(resp_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Emulates the UART: rx_rdy held until the edge following clr_rx_rdy.
  task automatic send_byte(input string tag, input logic [7:0] b, input logic ack);
    rx_rdy = 1'b1;
    rx_data = b;
    clr_cmd_rdy = ack;
    #1;
    chk({tag, "_clr"}, 16'(clr_rx_rdy), 16'h1);
    tick();
    rx_rdy = 1'b0;
    clr_cmd_rdy = 1'b0;
    #1;
    chk({tag, "_clr_low"}, 16'(clr_rx_rdy), 16'h0);
  endtask

  task automatic ack_cmd();
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_cmd", cmd, 16'h0000);
    chk("rst_cmd_rdy", 16'(cmd_rdy), 16'h0);
    chk("rst_trmt", 16'(trmt), 16'h0);
    chk("rst_tx_data", 16'(tx_data), 16'h0);
    chk("rst_pulses", 16'({frame_err, overrun, resp_drop, clr_rx_rdy}), 16'h0);
    tick();
    rst = 1'b0;
    tick();

    // Basic two-byte command
    send_byte("a5", 8'hA5, 1'b0);
    chk("a5_no_rdy", 16'(cmd_rdy), 16'h0);
    send_byte("3c", 8'h3C, 1'b0);
    chk("cmd_a53c", cmd, 16'hA53C);
    chk("rdy_a53c", 16'(cmd_rdy), 16'h1);
    chk("ovr_a53c", 16'(overrun), 16'h0);
    ack_cmd();
    chk("ack_rdy", 16'(cmd_rdy), 16'h0);
    chk("ack_cmd_hold", cmd, 16'hA53C);

    // Timeout: high byte 0x12 dropped after 16 idle cycles
    send_byte("12", 8'h12, 1'b0);
    for (int unsigned i = 0; i < 15; i++) tick();
    chk("to_pre_ferr", 16'(frame_err), 16'h0);
    tick();
    chk("to_ferr", 16'(frame_err), 16'h1);
    tick();
    chk("to_ferr_once", 16'(frame_err), 16'h0);
    send_byte("34", 8'h34, 1'b0);
    send_byte("56", 8'h56, 1'b0);
    chk("cmd_3456", cmd, 16'h3456);
    chk("rdy_3456", 16'(cmd_rdy), 16'h1);
    chk("ferr_3456", 16'(frame_err), 16'h0);
    ack_cmd();

    // Low byte on the terminal-count cycle is accepted
    send_byte("77", 8'h77, 1'b0);
    for (int unsigned i = 0; i < 15; i++) tick();
    send_byte("88", 8'h88, 1'b0);
    chk("cmd_7788", cmd, 16'h7788);
    chk("rdy_7788", 16'(cmd_rdy), 16'h1);
    chk("ferr_7788", 16'(frame_err), 16'h0);
    ack_cmd();

    // Overrun
    send_byte("11h", 8'h11, 1'b0);
    send_byte("11l", 8'h11, 1'b0);
    chk("ovr_first", 16'(overrun), 16'h0);
    send_byte("22h", 8'h22, 1'b0);
    chk("hi_keeps_rdy", 16'(cmd_rdy), 16'h1);
    send_byte("22l", 8'h22, 1'b0);
    chk("cmd_2222", cmd, 16'h2222);
    chk("ovr_second", 16'(overrun), 16'h1);
    tick();
    chk("ovr_pulse", 16'(overrun), 16'h0);
    send_byte("33h", 8'h33, 1'b0);
    send_byte("44l", 8'h44, 1'b1);
    chk("cmd_3344", cmd, 16'h3344);
    chk("set_wins", 16'(cmd_rdy), 16'h1);
    chk("ovr_acked", 16'(overrun), 16'h0);

    // TX path
    send_resp = 1'b1; resp = 8'hA5;
    tick();
    chk("trmt_a5", 16'(trmt), 16'h1);
    chk("txd_a5", 16'(tx_data), 16'h00A5);
    resp = 8'h5A;
    tick();
    chk("trmt_gap", 16'(trmt), 16'h0);
    chk("drop_5a", 16'(resp_drop), 16'h0);
    resp = 8'hFF;
    tick();
    send_resp = 1'b0;
    chk("drop_ff", 16'(resp_drop), 16'h1);
    chk("txd_hold", 16'(tx_data), 16'h00A5);
    tick();
    chk("drop_pulse", 16'(resp_drop), 16'h0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("trmt_5a", 16'(trmt), 16'h1);
    chk("txd_5a", 16'(tx_data), 16'h005A);
    tick();
    chk("trmt_5a_end", 16'(trmt), 16'h0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("idle_no_trmt", 16'(trmt), 16'h0);
    send_resp = 1'b1; resp = 8'h3C;
    tick();
    send_resp = 1'b0;
    chk("idle_launch", 16'(trmt), 16'h1);
    chk("txd_3c", 16'(tx_data), 16'h003C);
    tick();
    tx_done = 1'b1; send_resp = 1'b1; resp = 8'h99;
    tick();
    tx_done = 1'b0; send_resp = 1'b0;
    chk("done_send_trmt", 16'(trmt), 16'h1);
    chk("done_send_txd", 16'(tx_data), 16'h0099);
    chk("done_send_drop", 16'(resp_drop), 16'h0);
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;

    // Reset mid-frame with a buffered response and a pending command
    send_resp = 1'b1; resp = 8'h11;
    tick();
    resp = 8'h22;
    tick();
    send_resp = 1'b0;
    send_byte("55h", 8'h55, 1'b0);
    rst = 1'b1;
    #1;
    chk("mrst_cmd", cmd, 16'h0000);
    chk("mrst_rdy", 16'(cmd_rdy), 16'h0);
    chk("mrst_txd", 16'(tx_data), 16'h0);
    chk("mrst_pulses", 16'({trmt, frame_err, overrun, resp_drop, clr_rx_rdy}), 16'h0);
    #1;
    rst = 1'b0;
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("mrst_no_buf_trmt", 16'(trmt), 16'h0);
    tick();
    chk("mrst_no_trmt2", 16'(trmt), 16'h0);
    send_byte("00h", 8'h00, 1'b0);
    chk("mrst_hi_rdy", 16'(cmd_rdy), 16'h0);
    send_byte("07l", 8'h07, 1'b0);
    chk("cmd_0007", cmd, 16'h0007);
    chk("rdy_0007", 16'(cmd_rdy), 16'h1);
    chk("ovr_0007", 16'(overrun), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
